// File: rtl/mem_port_arbiter.sv
// Shares one single-port data RAM between fetch (read-only) and the memory stage (load/store).
// Latency: grant in IDLE, MEM_LATENCY ACCESS cycles, valid pulse in DONE; one access per MEM_LATENCY+2 cycles.
// Backpressure: level requests wait while busy; MEM has priority, fetch wins after STARVE_LIMIT MEM grants.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = 3,
    parameter int STARVE_LIMIT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_valid,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int STK_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LAT_M1  = CNT_W'(MEM_LATENCY - 1);
    localparam logic [STK_W-1:0] STK_MAX = STK_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [STK_W-1:0]  streak;
    logic              owner_mem;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              grant_if;
    logic              grant_mem;
    logic              last_access;

    assign last_access = (state == ACCESS) && (cnt == '0);

    // Fetch only loses a tie while the MEM streak is below the limit.
    always_comb begin
        grant_mem = 1'b0;
        grant_if  = 1'b0;
        if (state == IDLE) begin
            if (mem_req && (!if_req || (streak != STK_MAX))) begin
                grant_mem = 1'b1;
            end else if (if_req) begin
                grant_if = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if_valid  = 1'b0;
        mem_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (grant_if || grant_mem) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                ram_en    = 1'b1;
                ram_we    = we_q && owner_mem && (cnt == LAT_M1);
                ram_addr  = addr_q;
                ram_wdata = wdata_q;
                if (cnt == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if_valid  = !owner_mem;
                mem_valid = owner_mem;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            streak    <= '0;
            owner_mem <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            if_rdata  <= '0;
            mem_rdata <= '0;
        end else begin
            if (grant_mem) begin
                cnt       <= LAT_M1;
                owner_mem <= 1'b1;
                we_q      <= mem_we;
                addr_q    <= mem_addr;
                wdata_q   <= mem_wdata;
                if (!if_req) begin
                    streak <= '0;
                end else if (streak != STK_MAX) begin
                    streak <= streak + STK_W'(1);
                end
            end else if (grant_if) begin
                cnt       <= LAT_M1;
                owner_mem <= 1'b0;
                we_q      <= 1'b0;
                addr_q    <= if_addr;
                wdata_q   <= '0;
                streak    <= '0;
            end else if ((state == ACCESS) && (cnt != '0)) begin
                cnt <= cnt - CNT_W'(1);
            end

            // Read data lands at the end of the last ACCESS cycle, visible with the valid pulse.
            if (last_access && !we_q) begin
                if (owner_mem) begin
                    mem_rdata <= ram_rdata;
                end else begin
                    if_rdata <= ram_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, fetch read, store, starvation order,
// reset mid-access and back-to-back loads. Inputs change and outputs are sampled at negedge.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_valid;
    logic [31:0] mem_rdata;
    logic        ram_en;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3), .STARVE_LIMIT(2)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_valid(mem_valid), .mem_rdata(mem_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .busy(busy)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        if_req    = 1'($urandom);
        if_addr   = $urandom;
        mem_req   = 1'($urandom);
        mem_we    = 1'($urandom);
        mem_addr  = $urandom;
        mem_wdata = $urandom;
        ram_rdata = $urandom;
        repeat (3) step();
        n_checks++;
        if ({if_valid, mem_valid, ram_en, ram_we, busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 00000", {if_valid, mem_valid, ram_en, ram_we, busy});
        end
        n_checks++;
        if ({if_rdata, mem_rdata} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h/%h expected 0/0", if_rdata, mem_rdata);
        end
        n_checks++;
        if ({ram_addr, ram_wdata} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_ram_bus: got %h/%h expected 0/0", ram_addr, ram_wdata);
        end
        if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
        if_addr = '0; mem_addr = '0; mem_wdata = '0; ram_rdata = '0;
        reset = 1'b1;
        step();
        step();
        n_checks++;
        if ({busy, ram_en} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_release_idle: got busy/en %b expected 00", {busy, ram_en});
        end
    endtask

    task automatic test_if_read();
        if_req  = 1'b1;
        if_addr = 32'h10;
        ram_rdata = 32'h0BAD_F00D;
        for (int c = 1; c <= 5; c++) begin
            step();
            if (c == 1) begin
                if_req  = 1'b0;
                if_addr = 32'hFFFF_FFFF;
            end
            if (c <= 3) begin
                n_checks++;
                if ({ram_en, ram_we, ram_addr, busy} !== {1'b1, 1'b0, 32'h10, 1'b1}) begin
                    n_fail++;
                    $display("FAIL if_access c%0d: got en=%b we=%b addr=%h busy=%b expected 1 0 00000010 1",
                             c, ram_en, ram_we, ram_addr, busy);
                end
            end
            if (c == 3) ram_rdata = 32'hDEAD_BEEF;
            if (c == 4) begin
                n_checks++;
                if ({if_valid, mem_valid, ram_en, if_rdata} !== {1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF}) begin
                    n_fail++;
                    $display("FAIL if_done: got ifv=%b memv=%b en=%b rdata=%h expected 1 0 0 deadbeef",
                             if_valid, mem_valid, ram_en, if_rdata);
                end
                ram_rdata = 32'h5555_5555;
            end
            if (c == 5) begin
                n_checks++;
                if ({if_valid, busy, if_rdata} !== {1'b0, 1'b0, 32'hDEAD_BEEF}) begin
                    n_fail++;
                    $display("FAIL if_hold: got ifv=%b busy=%b rdata=%h expected 0 0 deadbeef",
                             if_valid, busy, if_rdata);
                end
            end
        end
    endtask

    task automatic test_store();
        // Preload mem_rdata with 0xAAAA through a load.
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h30; ram_rdata = 32'h0000_AAAA;
        step();
        mem_req = 1'b0;
        repeat (4) step();
        n_checks++;
        if (mem_rdata !== 32'h0000_AAAA) begin
            n_fail++;
            $display("FAIL store_preload: got %h expected 0000aaaa", mem_rdata);
        end
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h20; mem_wdata = 32'h1234;
        ram_rdata = 32'h9999_9999;
        for (int c = 1; c <= 5; c++) begin
            step();
            if (c == 1) begin
                mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
            end
            if (c <= 3) begin
                n_checks++;
                if ({ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, (c == 1), 32'h20, 32'h1234}) begin
                    n_fail++;
                    $display("FAIL store_access c%0d: got en=%b we=%b addr=%h wdata=%h expected 1 %0d 20 1234",
                             c, ram_en, ram_we, ram_addr, ram_wdata, (c == 1));
                end
            end
            if (c == 4) begin
                n_checks++;
                if ({mem_valid, if_valid, ram_en, ram_we, mem_rdata, if_rdata} !==
                    {1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_AAAA, 32'hDEAD_BEEF}) begin
                    n_fail++;
                    $display("FAIL store_done: got memv=%b ifv=%b en=%b we=%b mrd=%h ird=%h expected 1 0 0 0 aaaa deadbeef",
                             mem_valid, if_valid, ram_en, ram_we, mem_rdata, if_rdata);
                end
            end
            if (c == 5) begin
                n_checks++;
                if ({mem_valid, busy, ram_wdata} !== {1'b0, 1'b0, 32'h0}) begin
                    n_fail++;
                    $display("FAIL store_idle: got memv=%b busy=%b wdata=%h expected 0 0 0",
                             mem_valid, busy, ram_wdata);
                end
            end
        end
    endtask

    task automatic test_starvation();
        logic exp_mem [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        int   nvalid;
        if_req = 1'b1; if_addr = 32'h200;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h100;
        for (int g = 0; g < 6; g++) begin
            nvalid = 0;
            ram_rdata = 32'hC000_0000 + 32'(g);
            for (int c = 1; c <= 5; c++) begin
                step();
                nvalid += int'(if_valid) + int'(mem_valid);
                if (c == 1) begin
                    n_checks++;
                    if (ram_addr !== (exp_mem[g] ? 32'h100 : 32'h200)) begin
                        n_fail++;
                        $display("FAIL starve_grant g%0d: got addr %h expected %h",
                                 g, ram_addr, (exp_mem[g] ? 32'h100 : 32'h200));
                    end
                end
                if (c == 4) begin
                    n_checks++;
                    if ({mem_valid, if_valid} !== {exp_mem[g], !exp_mem[g]}) begin
                        n_fail++;
                        $display("FAIL starve_valid g%0d: got memv/ifv %b%b expected %b%b",
                                 g, mem_valid, if_valid, exp_mem[g], !exp_mem[g]);
                    end
                    if (g == 5) begin
                        if_req = 1'b0; mem_req = 1'b0;
                    end
                end
                if (c == 5) begin
                    n_checks++;
                    if ({busy, nvalid} !== {1'b0, 32'd1}) begin
                        n_fail++;
                        $display("FAIL starve_window g%0d: got busy=%b valids=%0d expected 0 1", g, busy, nvalid);
                    end
                end
            end
        end
        n_checks++;
        if ({mem_rdata, if_rdata} !== {32'hC000_0004, 32'hC000_0005}) begin
            n_fail++;
            $display("FAIL starve_rdata: got %h/%h expected c0000004/c0000005", mem_rdata, if_rdata);
        end
    endtask

    task automatic test_reset_mid_access();
        int nvalid = 0;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h40; mem_wdata = 32'h55;
        step();
        mem_req = 1'b0; mem_we = 1'b0;
        n_checks++;
        if ({ram_en, ram_we} !== 2'b11) begin
            n_fail++;
            $display("FAIL rstmid_first: got en/we %b expected 11", {ram_en, ram_we});
        end
        step();
        reset = 1'b0;
        #1;
        n_checks++;
        if ({ram_en, ram_we, busy, ram_addr} !== {3'b000, 32'h0}) begin
            n_fail++;
            $display("FAIL rstmid_abort: got en=%b we=%b busy=%b addr=%h expected 0 0 0 0",
                     ram_en, ram_we, busy, ram_addr);
        end
        repeat (2) step();
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            nvalid += int'(mem_valid) + int'(if_valid);
        end
        n_checks++;
        if ({nvalid, busy} !== {32'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL rstmid_novalid: got valids=%0d busy=%b expected 0 0", nvalid, busy);
        end
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h44; ram_rdata = 32'h77;
        step();
        mem_req = 1'b0;
        n_checks++;
        if ({ram_en, ram_addr} !== {1'b1, 32'h44}) begin
            n_fail++;
            $display("FAIL rstmid_regrant: got en=%b addr=%h expected 1 44", ram_en, ram_addr);
        end
        repeat (3) step();
        n_checks++;
        if ({mem_valid, mem_rdata} !== {1'b1, 32'h77}) begin
            n_fail++;
            $display("FAIL rstmid_load: got memv=%b rdata=%h expected 1 77", mem_valid, mem_rdata);
        end
        step();
    endtask

    task automatic test_back_to_back();
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h28; ram_rdata = 32'h1111_1111;
        repeat (4) step();
        n_checks++;
        if ({mem_valid, mem_rdata} !== {1'b1, 32'h1111_1111}) begin
            n_fail++;
            $display("FAIL b2b_first: got memv=%b rdata=%h expected 1 11111111", mem_valid, mem_rdata);
        end
        mem_addr = 32'h24;
        step();
        n_checks++;
        if ({busy, mem_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL b2b_idle: got busy/memv %b expected 00", {busy, mem_valid});
        end
        step();
        mem_req = 1'b0;
        ram_rdata = 32'h2222_2222;
        n_checks++;
        if ({ram_en, ram_addr} !== {1'b1, 32'h24}) begin
            n_fail++;
            $display("FAIL b2b_regrant: got en=%b addr=%h expected 1 24", ram_en, ram_addr);
        end
        step();
        step();
        n_checks++;
        if ({mem_valid, mem_rdata} !== {1'b0, 32'h1111_1111}) begin
            n_fail++;
            $display("FAIL b2b_hold: got memv=%b rdata=%h expected 0 11111111", mem_valid, mem_rdata);
        end
        step();
        n_checks++;
        if ({mem_valid, mem_rdata} !== {1'b1, 32'h2222_2222}) begin
            n_fail++;
            $display("FAIL b2b_second: got memv=%b rdata=%h expected 1 22222222", mem_valid, mem_rdata);
        end
        step();
        n_checks++;
        if ({mem_valid, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL b2b_end: got memv/busy %b expected 00", {mem_valid, busy});
        end
    endtask

    initial begin
        reset = 1'b0;
        if_req = 1'b0; if_addr = '0;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
        ram_rdata = '0;
        step();
        test_reset();
        test_if_read();
        test_store();
        test_starvation();
        test_reset_mid_access();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
